// File: rtl/csr_pkg.sv
// Shared constants for the WB-stage CSR file: addresses, writable-bit masks,
// reset values and field positions.
package csr_pkg;

  localparam int ECODE_W = 7;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ECFG   = 14'h0004;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_BADV   = 14'h0007;
  localparam logic [13:0] CSR_EENTRY = 14'h000C;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;
  localparam logic [13:0] CSR_SAVE1  = 14'h0031;
  localparam logic [13:0] CSR_SAVE2  = 14'h0032;
  localparam logic [13:0] CSR_SAVE3  = 14'h0033;
  localparam logic [13:0] CSR_TID    = 14'h0040;
  localparam logic [13:0] CSR_TCFG   = 14'h0041;
  localparam logic [13:0] CSR_TVAL   = 14'h0042;
  localparam logic [13:0] CSR_TICLR  = 14'h0044;

  localparam logic [31:0] WMASK_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
  localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] WMASK_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] WMASK_EENTRY = 32'hFFFF_FFC0;
  localparam logic [31:0] WMASK_FULL   = 32'hFFFF_FFFF;
  localparam logic [31:0] WMASK_TICLR  = 32'h0000_0001;
  localparam logic [31:0] WMASK_NONE   = 32'h0000_0000;

  localparam logic [31:0] RST_CRMD  = 32'h0000_0008;
  localparam logic [31:0] RST_OTHER = 32'h0000_0000;

  localparam int CRMD_PLV_LO     = 0;
  localparam int CRMD_PLV_HI     = 1;
  localparam int CRMD_IE         = 2;
  localparam int PRMD_PPLV_LO    = 0;
  localparam int PRMD_PPLV_HI    = 1;
  localparam int PRMD_PIE        = 2;
  localparam int ESTAT_IS_HI     = 12;
  localparam int ESTAT_HWI_LO    = 2;
  localparam int ESTAT_HWI_HI    = 9;
  localparam int ESTAT_TI        = 11;
  localparam int ESTAT_ECODE_LO  = 16;
  localparam int ESTAT_ECODE_HI  = 21;
  localparam int ESTAT_ESUB0     = 22;
  localparam int TCFG_EN         = 0;
  localparam int TCFG_PERIODIC   = 1;
  localparam int TCFG_INIT_LO    = 2;

  function automatic logic [31:0] csr_wmask(input logic [13:0] addr);
    case (addr)
      CSR_CRMD:   return WMASK_CRMD;
      CSR_PRMD:   return WMASK_PRMD;
      CSR_ECFG:   return WMASK_ECFG;
      CSR_ESTAT:  return WMASK_ESTAT;
      CSR_EENTRY: return WMASK_EENTRY;
      CSR_TICLR:  return WMASK_TICLR;
      CSR_ERA, CSR_BADV, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
      CSR_TID, CSR_TCFG: return WMASK_FULL;
      default:    return WMASK_NONE;
    endcase
  endfunction

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wdata,
                                            input logic [31:0] m);
    return (old_v & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_file_wb_if.sv
// WB sideband into the CSR file and the read/flush/interrupt returns to the
// front of the pipeline.
interface csr_file_wb_if;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [13:0] WB_csr_waddr;
  logic [31:0] WB_csr_we;
  logic [31:0] WB_csr_wdata;
  logic [6:0]  WB_ecode_in;
  logic        WB_ecode_we;
  logic [31:0] WB_badv_in;
  logic        WB_badv_we;
  logic [31:0] WB_era_in;
  logic        WB_era_we;
  logic        WB_era_en;
  logic        WB_eentry_en;
  logic        WB_store_state;
  logic        WB_restore_state;
  logic        WB_flush_csr;
  logic [7:0]  hw_int;
  logic        MEM_interrupt;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic [63:0] EX_rdcntv;
  logic [31:0] EX_rdcntid;

  modport master (
    output csr_raddr, WB_csr_waddr, WB_csr_we, WB_csr_wdata,
           WB_ecode_in, WB_ecode_we, WB_badv_in, WB_badv_we,
           WB_era_in, WB_era_we, WB_era_en, WB_eentry_en,
           WB_store_state, WB_restore_state, WB_flush_csr, hw_int,
    input  csr_rdata, MEM_interrupt, flush_valid, flush_pc,
           EX_rdcntv, EX_rdcntid
  );

  modport slave (
    input  csr_raddr, WB_csr_waddr, WB_csr_we, WB_csr_wdata,
           WB_ecode_in, WB_ecode_we, WB_badv_in, WB_badv_we,
           WB_era_in, WB_era_we, WB_era_en, WB_eentry_en,
           WB_store_state, WB_restore_state, WB_flush_csr, hw_int,
    output csr_rdata, MEM_interrupt, flush_valid, flush_pc,
           EX_rdcntv, EX_rdcntid
  );
endinterface

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer; raises the timer interrupt bit on each 1->0 step.
// A TCFG write reloads TVAL that cycle; timer set beats a same-cycle TICLR clear.
module csr_timer
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] tcfg_we_i,
  input  logic [31:0] tcfg_wdata_i,
  input  logic        ticlr_clr_i,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o,
  output logic        ti_o
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        ti_q, ti_d;

  always_comb begin
    tcfg_d = csr_merge(tcfg_q, tcfg_wdata_i, tcfg_we_i);
    tval_d = tval_q;
    ti_d   = ti_q;
    if (ticlr_clr_i) ti_d = 1'b0;
    if (|tcfg_we_i) begin
      tval_d = {tcfg_wdata_i[31:TCFG_INIT_LO], 2'b00};
    end else if (tcfg_q[TCFG_EN] && tval_q != 32'd0) begin
      if (tval_q == 32'd1) begin
        ti_d   = 1'b1;
        tval_d = tcfg_q[TCFG_PERIODIC] ? {tcfg_q[31:TCFG_INIT_LO], 2'b00} : 32'd0;
      end else begin
        tval_d = tval_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcfg_q <= RST_OTHER;
      tval_q <= RST_OTHER;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign tcfg_o = tcfg_q;
  assign tval_o = tval_q;
  assign ti_o   = ti_q;

endmodule

// File: rtl/csr_file_wb.sv
// Architectural CSR file at WB: masked software writes, exception/ertn updates,
// stable counter and registered interrupt request. Reads are combinational.
module csr_file_wb
  import csr_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  csr_file_wb_if.slave bus
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [63:0] cnt_q;
  logic        int_q;

  logic [31:0] wm, tcfg_we, tcfg, tval, estat_rd, rdata;
  logic        ticlr_clr, ti;

  assign wm        = bus.WB_csr_we & csr_wmask(bus.WB_csr_waddr);
  assign tcfg_we   = (bus.WB_csr_waddr == CSR_TCFG) ? wm : 32'd0;
  assign ticlr_clr = (bus.WB_csr_waddr == CSR_TICLR) && wm[0] && bus.WB_csr_wdata[0];

  csr_timer u_timer (
    .clk_i       (clk),
    .rst_i       (rst),
    .tcfg_we_i   (tcfg_we),
    .tcfg_wdata_i(bus.WB_csr_wdata),
    .ticlr_clr_i (ticlr_clr),
    .tcfg_o      (tcfg),
    .tval_o      (tval),
    .ti_o        (ti)
  );

  // Software merge first, hardware updates afterwards so they win on collision.
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    for (int i = 0; i < 4; i++) save_d[i] = save_q[i];
    case (bus.WB_csr_waddr)
      CSR_CRMD:   crmd_d    = csr_merge(crmd_q,   bus.WB_csr_wdata, wm);
      CSR_PRMD:   prmd_d    = csr_merge(prmd_q,   bus.WB_csr_wdata, wm);
      CSR_ECFG:   ecfg_d    = csr_merge(ecfg_q,   bus.WB_csr_wdata, wm);
      CSR_ESTAT:  estat_d   = csr_merge(estat_q,  bus.WB_csr_wdata, wm);
      CSR_ERA:    era_d     = csr_merge(era_q,    bus.WB_csr_wdata, wm);
      CSR_BADV:   badv_d    = csr_merge(badv_q,   bus.WB_csr_wdata, wm);
      CSR_EENTRY: eentry_d  = csr_merge(eentry_q, bus.WB_csr_wdata, wm);
      CSR_TID:    tid_d     = csr_merge(tid_q,    bus.WB_csr_wdata, wm);
      CSR_SAVE0:  save_d[0] = csr_merge(save_q[0], bus.WB_csr_wdata, wm);
      CSR_SAVE1:  save_d[1] = csr_merge(save_q[1], bus.WB_csr_wdata, wm);
      CSR_SAVE2:  save_d[2] = csr_merge(save_q[2], bus.WB_csr_wdata, wm);
      CSR_SAVE3:  save_d[3] = csr_merge(save_q[3], bus.WB_csr_wdata, wm);
      default: ;
    endcase
    if (bus.WB_store_state) begin
      prmd_d[PRMD_PPLV_HI:PRMD_PPLV_LO] = crmd_q[CRMD_PLV_HI:CRMD_PLV_LO];
      prmd_d[PRMD_PIE]                  = crmd_q[CRMD_IE];
      crmd_d[CRMD_PLV_HI:CRMD_PLV_LO]   = 2'b00;
      crmd_d[CRMD_IE]                   = 1'b0;
    end
    if (bus.WB_restore_state) begin
      crmd_d[CRMD_PLV_HI:CRMD_PLV_LO] = prmd_q[PRMD_PPLV_HI:PRMD_PPLV_LO];
      crmd_d[CRMD_IE]                 = prmd_q[PRMD_PIE];
    end
    estat_d[ESTAT_HWI_HI:ESTAT_HWI_LO] = bus.hw_int;
    if (bus.WB_ecode_we) begin
      estat_d[ESTAT_ECODE_HI:ESTAT_ECODE_LO] = bus.WB_ecode_in[5:0];
      estat_d[ESTAT_ESUB0]                   = bus.WB_ecode_in[ECODE_W-1];
    end
    if (bus.WB_era_we)  era_d  = bus.WB_era_in;
    if (bus.WB_badv_we) badv_d = bus.WB_badv_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q   <= RST_CRMD;
      prmd_q   <= RST_OTHER;
      ecfg_q   <= RST_OTHER;
      estat_q  <= RST_OTHER;
      era_q    <= RST_OTHER;
      badv_q   <= RST_OTHER;
      eentry_q <= RST_OTHER;
      tid_q    <= RST_OTHER;
      for (int i = 0; i < 4; i++) save_q[i] <= RST_OTHER;
      cnt_q    <= 64'd0;
      int_q    <= 1'b0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
      cnt_q    <= cnt_q + 64'd1;
      int_q    <= crmd_q[CRMD_IE] & |(estat_rd[ESTAT_IS_HI:0] & ecfg_q[ESTAT_IS_HI:0]);
    end
  end

  // The timer bit lives in csr_timer; estat_q keeps that position zero.
  always_comb begin
    estat_rd           = estat_q;
    estat_rd[ESTAT_TI] = ti;
  end

  always_comb begin
    rdata = 32'd0;
    case (bus.csr_raddr)
      CSR_CRMD:   rdata = crmd_q;
      CSR_PRMD:   rdata = prmd_q;
      CSR_ECFG:   rdata = ecfg_q;
      CSR_ESTAT:  rdata = estat_rd;
      CSR_ERA:    rdata = era_q;
      CSR_BADV:   rdata = badv_q;
      CSR_EENTRY: rdata = eentry_q;
      CSR_SAVE0:  rdata = save_q[0];
      CSR_SAVE1:  rdata = save_q[1];
      CSR_SAVE2:  rdata = save_q[2];
      CSR_SAVE3:  rdata = save_q[3];
      CSR_TID:    rdata = tid_q;
      CSR_TCFG:   rdata = tcfg;
      CSR_TVAL:   rdata = tval;
      default:    rdata = 32'd0;
    endcase
  end

  // EENTRY is the default flush target, so the explicit select is redundant.
  logic unused_eentry_en;
  assign unused_eentry_en = bus.WB_eentry_en;

  assign bus.csr_rdata     = rdata;
  assign bus.MEM_interrupt = int_q;
  assign bus.flush_valid   = bus.WB_flush_csr;
  assign bus.flush_pc      = bus.WB_era_en ? era_q : eentry_q;
  assign bus.EX_rdcntv     = cnt_q;
  assign bus.EX_rdcntid    = tid_q;

endmodule

// File: tb/tb_csr_file_wb.sv
// Directed bench for csr_file_wb: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_csr_file_wb;
  import csr_pkg::*;

  localparam logic [2:0] K_RD = 3'd0, K_INT = 3'd1, K_FV = 3'd2,
                         K_FPC = 3'd3, K_CNT = 3'd4, K_TID = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] expv;
    logic [95:0] name;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_file_wb_if bus ();
  csr_file_wb dut (.clk(clk), .rst(rst), .bus(bus));

  item_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc_n = 0;
  bit    done  = 1'b0;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      item_t it;
      logic [63:0] act;
      it = sb_q.pop_front();
      case (it.kind)
        K_RD:    act = {32'd0, bus.csr_rdata};
        K_INT:   act = {63'd0, bus.MEM_interrupt};
        K_FV:    act = {63'd0, bus.flush_valid};
        K_FPC:   act = {32'd0, bus.flush_pc};
        K_CNT:   act = bus.EX_rdcntv;
        default: act = {32'd0, bus.EX_rdcntid};
      endcase
      n_cmp++;
      if (act !== it.expv) begin
        n_bad++;
        $display("FAIL %0s: got %h expected %h", it.name, act, it.expv);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: stimulus did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic check_now(input logic [63:0] act, input logic [63:0] e, input logic [95:0] n);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %0s: got %h expected %h", n, act, e);
    end
  endtask

  task automatic idle();
    bus.WB_csr_waddr     = 14'd0;
    bus.WB_csr_we        = 32'd0;
    bus.WB_csr_wdata     = 32'd0;
    bus.WB_ecode_in      = 7'd0;
    bus.WB_ecode_we      = 1'b0;
    bus.WB_badv_in       = 32'd0;
    bus.WB_badv_we       = 1'b0;
    bus.WB_era_in        = 32'd0;
    bus.WB_era_we        = 1'b0;
    bus.WB_era_en        = 1'b0;
    bus.WB_eentry_en     = 1'b0;
    bus.WB_store_state   = 1'b0;
    bus.WB_restore_state = 1'b0;
    bus.WB_flush_csr     = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    cyc_n++;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.WB_csr_waddr = a;
    bus.WB_csr_we    = 32'hFFFF_FFFF;
    bus.WB_csr_wdata = d;
  endtask

  task automatic expect_sig(input logic [2:0] k, input logic [63:0] e, input logic [95:0] n);
    item_t it;
    it.kind = k;
    it.expv = e;
    it.name = n;
    sb_q.push_back(it);
  endtask

  task automatic exp_rd(input logic [13:0] a, input logic [31:0] e, input logic [95:0] n);
    bus.csr_raddr = a;
    expect_sig(K_RD, {32'd0, e}, n);
  endtask

  initial begin
    bus.csr_raddr = 14'd0;
    bus.hw_int    = 8'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    cyc_n = 0;
    bus.csr_raddr = CSR_CRMD;
    #1;
    check_now({32'd0, bus.csr_rdata}, 64'h8, "crmd_rst_now");
    check_now(bus.EX_rdcntv, 64'd0, "cnt_rst_now");
    // C0: reset values
    exp_rd(CSR_CRMD, 32'h8, "crmd_rst");
    expect_sig(K_CNT, 64'd0, "cnt_rst");
    expect_sig(K_INT, 64'd0, "int_rst");
    cyc();
    exp_rd(14'h7FF, 32'h0, "unimpl");
    expect_sig(K_CNT, 64'(cyc_n), "cnt_c1");
    cyc();
    exp_rd(CSR_ESTAT, 32'h0, "estat_rst");
    expect_sig(K_TID, 64'd0, "tid_rst");
    cyc();
    // Masked CRMD write; same-cycle read sees the old value
    wr(CSR_CRMD, 32'hFFFF_FFFF);
    exp_rd(CSR_CRMD, 32'h8, "crmd_nobyp");
    cyc();
    exp_rd(CSR_CRMD, 32'h1FF, "crmd_mask");
    wr(CSR_CRMD, 32'h7);
    cyc();
    // Exception entry with a colliding PRMD software write
    exp_rd(CSR_CRMD, 32'h7, "crmd_7");
    wr(CSR_PRMD, 32'h0);
    bus.WB_store_state = 1'b1;
    bus.WB_ecode_we = 1'b1;  bus.WB_ecode_in = 7'h48;
    bus.WB_era_we   = 1'b1;  bus.WB_era_in   = 32'h1C00_0100;
    bus.WB_badv_we  = 1'b1;  bus.WB_badv_in  = 32'hDEAD_BEEF;
    bus.WB_flush_csr = 1'b1; bus.WB_eentry_en = 1'b1;
    expect_sig(K_FV, 64'd1, "fv_exc");
    expect_sig(K_FPC, 64'd0, "fpc_exc");
    cyc();
    exp_rd(CSR_CRMD, 32'h0, "crmd_exc");
    cyc();
    exp_rd(CSR_PRMD, 32'h7, "prmd_exc");
    cyc();
    exp_rd(CSR_ESTAT, 32'h0048_0000, "estat_ecode");
    cyc();
    exp_rd(CSR_ERA, 32'h1C00_0100, "era_exc");
    cyc();
    // ertn with a same-cycle ERA load: flush uses the old ERA
    exp_rd(CSR_BADV, 32'hDEAD_BEEF, "badv");
    bus.WB_restore_state = 1'b1;
    bus.WB_flush_csr = 1'b1; bus.WB_era_en = 1'b1;
    bus.WB_era_we = 1'b1;    bus.WB_era_in = 32'h1C00_0200;
    expect_sig(K_FPC, 64'h1C00_0100, "fpc_ertn");
    cyc();
    exp_rd(CSR_CRMD, 32'h7, "crmd_ertn");
    expect_sig(K_FV, 64'd0, "fv_idle");
    cyc();
    exp_rd(CSR_ERA, 32'h1C00_0200, "era_new");
    wr(CSR_EENTRY, 32'h1C00_8033);
    cyc();
    exp_rd(CSR_EENTRY, 32'h1C00_8000, "eentry");
    bus.WB_flush_csr = 1'b1; bus.WB_eentry_en = 1'b1;
    expect_sig(K_FPC, 64'h1C00_8000, "fpc_eentry");
    wr(CSR_ECFG, 32'hFFFF_FFFF);
    cyc();
    // hw_int with a same-cycle exception entry never raises the request
    exp_rd(CSR_ECFG, 32'h1BFF, "ecfg_mask");
    bus.hw_int = 8'h01;
    bus.WB_store_state = 1'b1;
    cyc();
    exp_rd(CSR_ESTAT, 32'h0048_0004, "estat_hwi");
    expect_sig(K_INT, 64'd0, "int_blk0");
    cyc();
    expect_sig(K_INT, 64'd0, "int_blk1");
    bus.WB_restore_state = 1'b1;
    cyc();
    exp_rd(CSR_CRMD, 32'h7, "crmd_rest2");
    expect_sig(K_INT, 64'd0, "int_blk2");
    cyc();
    expect_sig(K_INT, 64'd1, "int_ie_on");
    bus.hw_int = 8'h00;
    cyc();
    expect_sig(K_INT, 64'd1, "int_hold");
    cyc();
    expect_sig(K_INT, 64'd0, "int_drop");
    bus.hw_int = 8'h01;
    cyc();
    expect_sig(K_INT, 64'd0, "int_hw_l1");
    cyc();
    expect_sig(K_INT, 64'd1, "int_hw_l2");
    bus.hw_int = 8'h00;
    bus.WB_store_state = 1'b1;
    cyc();
    expect_sig(K_INT, 64'd1, "int_st_l1");
    cyc();
    expect_sig(K_INT, 64'd0, "int_st_l2");
    bus.WB_restore_state = 1'b1;
    cyc();
    // Periodic timer, InitVal=2 -> reload value 8
    wr(CSR_TCFG, 32'h0000_000B);
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp_rd(CSR_TVAL, 32'(8 - k), "tval_run");
      expect_sig(K_INT, 64'd0, "int_tmr0");
    end
    cyc();
    exp_rd(CSR_TVAL, 32'h8, "tval_wrap");
    expect_sig(K_INT, 64'd0, "int_tmr1");
    cyc();
    exp_rd(CSR_ESTAT, 32'h0048_0800, "estat_ti");
    expect_sig(K_INT, 64'd1, "int_timer");
    wr(CSR_TICLR, 32'h1);
    cyc();
    exp_rd(CSR_ESTAT, 32'h0048_0000, "estat_ticlr");
    expect_sig(K_INT, 64'd1, "int_tc_l0");
    cyc();
    expect_sig(K_INT, 64'd0, "int_tc_l1");
    exp_rd(CSR_TICLR, 32'h0, "ticlr_rd");
    wr(CSR_TCFG, 32'h0);
    cyc();
    exp_rd(CSR_TCFG, 32'h0, "tcfg_off");
    wr(CSR_TID, 32'h5A);
    cyc();
    expect_sig(K_TID, 64'h5A, "rdcntid");
    exp_rd(CSR_TVAL, 32'h0, "tval_off");
    wr(CSR_SAVE2, 32'h1234_5678);
    cyc();
    exp_rd(CSR_SAVE2, 32'h1234_5678, "save2");
    expect_sig(K_CNT, 64'(cyc_n), "cnt_mid");
    wr(CSR_TCFG, 32'h0000_000B);
    repeat (9) cyc();
    // Reset in the middle of a count
    exp_rd(CSR_ESTAT, 32'h0048_0800, "estat_ti2");
    rst = 1'b1;
    cyc();
    rst   = 1'b0;
    cyc_n = 0;
    exp_rd(CSR_ESTAT, 32'h0, "estat_rst2");
    expect_sig(K_CNT, 64'd0, "cnt_rst2");
    expect_sig(K_INT, 64'd0, "int_rst2");
    cyc();
    exp_rd(CSR_TVAL, 32'h0, "tval_rst2");
    expect_sig(K_CNT, 64'd1, "cnt_rst2b");
    cyc();
    exp_rd(CSR_CRMD, 32'h8, "crmd_rst2");
    wr(CSR_ESTAT, 32'hFFFF_FFFF);
    cyc();
    exp_rd(CSR_ESTAT, 32'h3, "estat_sw");
    @(posedge clk);
    #1;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
